// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Fetch-stage program-counter sequencer. It owns the architectural fetch PC
// and selects the next value internally from: exception vector, EX branch
// redirect, ID jump redirect (including return prediction), stall hold and
// sequential increment. A small circular return-address stack (RAS) records
// link addresses pushed by calls and supplies predicted targets for returns.
//
// Parameters
//   WIDTH        PC / address width in bits
//   RESET_VECTOR PC loaded by reset (truncated to WIDTH)
//   EXC_VECTOR   PC loaded on exception (truncated to WIDTH)
//   INC          sequential increment in bytes
//   RAS_DEPTH    return-address stack entries (power of two, >= 2)
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   stall               hold PC; only suppresses sequential advance
//   exc_req             exception request (highest-priority redirect)
//   br_taken/br_target  EX-stage taken branch and its target
//   jump/jump_target    ID-stage jump; jump_target is also the ret fallback
//   call/ret            qualify jump: push link_addr / pop RAS as target
//   link_addr           value pushed on call
//   PC                  registered fetch address
//   PC_plus_inc         PC + INC, combinational, modulo 2^WIDTH
//   redirect            high during the cycle a non-sequential PC is shown
//   ras_count           number of valid RAS entries
//   ras_empty/ras_full  ras_count == 0 / ras_count == RAS_DEPTH
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned INC          = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       exc_req,
  input  logic                       br_taken,
  input  logic [WIDTH-1:0]           br_target,
  input  logic                       jump,
  input  logic [WIDTH-1:0]           jump_target,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           link_addr,
  output logic [WIDTH-1:0]           PC,
  output logic [WIDTH-1:0]           PC_plus_inc,
  output logic                       redirect,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

  // Which source produced the next PC (purely a mux select, not an FSM).
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_EXC,
    SRC_BRANCH,
    SRC_RAS,
    SRC_JUMP
  } src_e;

  src_e             src;
  logic [WIDTH-1:0] next_pc;
  logic             next_redirect;

  // RAS state: ras_ptr addresses the current top entry whenever count > 0.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [WIDTH-1:0] ras_top;

  // RAS operations, only asserted when the jump is the winning source.
  logic             ras_push;     // call alone: write above top
  logic             ras_pop;      // ret alone on a non-empty stack
  logic             ras_replace;  // call and ret together: overwrite top
  logic [PTR_W-1:0] ras_wr_ptr;

  assign PC_plus_inc = PC + INC_W;
  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == CNT_MAX);
  assign ras_top     = ras_mem[ras_ptr];
  assign ras_wr_ptr  = ras_replace ? ras_ptr : ras_ptr + PTR_W'(1);

  // Next-PC selection. Redirects are checked before stall so that a stall
  // never holds back a redirect; stall only blocks sequential advance.
  always_comb begin
    src         = SRC_SEQ;
    next_pc     = PC_plus_inc;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    if (exc_req) begin
      src     = SRC_EXC;
      next_pc = EXC_PC;
    end else if (br_taken) begin
      src     = SRC_BRANCH;
      next_pc = br_target;
    end else if (jump) begin
      if (ret && !ras_empty) begin
        src     = SRC_RAS;
        next_pc = ras_top;
      end else begin
        src     = SRC_JUMP;
        next_pc = jump_target;
      end
      ras_push    = call && !ret;
      ras_pop     = ret && !call && !ras_empty;
      ras_replace = call && ret;
    end else if (stall) begin
      src     = SRC_HOLD;
      next_pc = PC;
    end
    next_redirect = (src != SRC_SEQ) && (src != SRC_HOLD);
  end

  // PC, redirect flag and RAS bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC        <= RESET_PC;
      redirect  <= 1'b0;
      ras_ptr   <= '0;
      ras_count <= '0;
    end else begin
      PC       <= next_pc;
      redirect <= next_redirect;
      if (ras_push) begin
        // When full, the pointer wraps onto the oldest entry and overwrites it.
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (!ras_full) begin
          ras_count <= ras_count + CNT_W'(1);
        end
      end else if (ras_pop) begin
        ras_ptr   <= ras_ptr - PTR_W'(1);
        ras_count <= ras_count - CNT_W'(1);
      end else if (ras_replace && ras_empty) begin
        ras_count <= CNT_W'(1);
      end
    end
  end

  // RAS storage has no reset; entries are only read when count > 0.
  always_ff @(posedge clk) begin
    if (!reset && (ras_push || ras_replace)) begin
      ras_mem[ras_wr_ptr] <= link_addr;
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage, successor to the fixed 32-bit `prog_counter`. It owns the architectural fetch PC and computes its next value internally, rather than taking a `next_PC` input. Sources are sequential increment, pipeline stall (hold), jump redirect from ID, branch redirect from EX, and exception vectoring. It also holds a small circular return-address stack (RAS) that predicts `jr $ra` targets from earlier `jal` pushes.

## Interface
Parameters:
- WIDTH, 32, PC / address width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (truncated to WIDTH)
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception (truncated to WIDTH)
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥ 2

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- stall  input  1  hold PC (hazard unit); sequential advance only
- exc_req  input  1  exception request; highest-priority redirect
- br_taken  input  1  EX-stage branch resolved taken
- br_target  input  WIDTH  branch target
- jump  input  1  ID-stage unconditional jump
- jump_target  input  WIDTH  jump target; also RAS-miss fallback for ret
- call  input  1  with jump: push link_addr (jal/jalr)
- ret  input  1  with jump: pop RAS as target (jr $ra)
- link_addr  input  WIDTH  value pushed on call
- PC  output  WIDTH  current fetch address (registered)
- PC_plus_inc  output  WIDTH  PC + INC, combinational from PC, modulo 2^WIDTH
- redirect  output  1  registered; 1 for the cycle after any non-sequential load
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_empty / ras_full  output  1 each  ras_count == 0 / == RAS_DEPTH

## Operation
- Next-PC priority, highest first:
  1. reset → RESET_VECTOR
  2. exc_req → EXC_VECTOR
  3. br_taken → br_target
  4. jump & ret & !ras_empty → RAS top
  5. jump & ret & ras_empty → jump_target
  6. jump → jump_target
  7. stall → PC (hold)
  8. else → PC + INC
- Redirects (items 2–6) take effect even when stall=1. A stall never suppresses a redirect.
- `call` and `ret` are ignored unless `jump`=1.
- RAS pointer rule: only for a ret/call accepted at priority 4–6. No change when exc_req or br_taken wins (wrong-path instruction squashed).
- Push (call only): write link_addr at top+1. Increment the count, saturating at RAS_DEPTH. When full, the oldest entry is overwritten (circular wrap).
- Pop (ret only, non-empty): read top, decrement the count, move the top pointer back one with wrap. A pop on empty leaves the count at 0.
- call & ret together: target = current top (or jump_target if empty). The top entry is then replaced by link_addr. Count unchanged if non-empty; 0→1 if empty.
- Arithmetic: PC + INC wraps modulo 2^WIDTH with no flag. Targets are loaded unmodified, with no alignment check.
- Reset state: PC=RESET_VECTOR, redirect=0, ras_count=0, RAS pointer 0. RAS contents are don't-care.

## Timing
- Single registered stage. A control input sampled at edge N is visible on PC after edge N; no combinational input→PC path.
- redirect is high exactly during the cycle in which the redirected PC is presented. Two back-to-back redirects keep redirect high for both cycles.
- Reset mid-operation (during stall, redirect or RAS activity) wins unconditionally. Next cycle: PC=RESET_VECTOR, RAS empty, redirect=0.
- Stall held for K cycles keeps PC constant for K cycles. Sequential advance resumes on the first edge with stall=0.

## Test plan
- Reset then free-run (defaults): PC 0x0, 0x4, 0x8, 0xC on successive cycles. redirect=0 throughout.
- Stall for 3 cycles at PC=0x8: PC stays 0x8 for 3 cycles, then 0xC. Then stall=1 with jump to 0x100: PC=0x100 next cycle, redirect=1.
- Simultaneous exc_req, br_taken (0x40) and jump (0x80): PC=0x80000180. Then br_taken + jump alone: PC=0x40. ras_count unchanged in both cases.
- RAS with RAS_DEPTH=4: calls with link 0x10, 0x20, 0x30, 0x40, 0x50 → ras_full, count=4. Four rets yield 0x50, 0x40, 0x30, 0x20. A fifth ret on empty goes to jump_target=0x99C.
- call+ret together with top=0x20 and link=0x60: PC=0x20, count unchanged, next ret yields 0x60. WIDTH=16 wrap: PC=0xFFFC advances to 0x0000.
- Reset asserted mid-sequence with RAS count 3 and stall=1: next PC=RESET_VECTOR, ras_empty=1, redirect=0.
